// File: rtl/sprite_motion_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sprite_motion_sched
//  Purpose  : Per-frame position scheduler for NUM_OBJ bouncing square
//             objects. An accepted frame tick walks every object once through
//             a shadow update (one object per cycle), then publishes all new
//             positions in a single edge so a frame is never seen half-done.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        : single clock, rising edge
//    rst        : synchronous active-high reset
//    frame_tick : one-cycle pulse at start of vertical blanking
//    enable     : gates acceptance of frame_tick
//    pause      : when high, frame_tick is ignored
//    speed[2:0] : pixels per frame per axis, sampled at tick acceptance
//    obj_x/obj_y: committed positions, object i at [10*i+9:10*i]
//    busy       : high while a frame update is in progress
//    done       : one-cycle pulse when new positions appear
//    overrun    : sticky, set when a tick arrives while busy
//    frame_cnt  : number of commits, wraps at 256
// ============================================================================
module sprite_motion_sched #(
    parameter int NUM_OBJ  = 4,
    parameter int OBJ_SIZE = 64,
    parameter int H_ACT    = 640,
    parameter int V_ACT    = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    enable,
    input  logic                    pause,
    input  logic [2:0]              speed,
    output logic [10*NUM_OBJ-1:0]   obj_x,
    output logic [10*NUM_OBJ-1:0]   obj_y,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic [7:0]              frame_cnt
);

    localparam int         c_IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [10:0] c_XLIM = 11'(H_ACT - OBJ_SIZE);
    localparam logic [10:0] c_YLIM = 11'(V_ACT - OBJ_SIZE);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_UPDATE = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [2:0]         r_speed;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;
    logic [7:0]         r_frame_cnt;
    logic               w_tick_ok;

    assign w_tick_ok = frame_tick & enable & ~pause;

    // One axis step. Returns {new_dir, new_pos}; dir=1 means moving positive.
    // The sum is formed in 11 bits so pos+speed can never wrap past the limit.
    function automatic logic [10:0] f_step(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [2:0]  spd,
        input logic [10:0] lim
    );
        logic [10:0] w_sum;
        logic [10:0] w_res;
        w_sum = {1'b0, pos} + {8'd0, spd};
        if (spd == 3'd0) begin
            w_res = {dir, pos};
        end else if (dir) begin
            if (w_sum >= lim) w_res = {1'b0, lim[9:0]};
            else              w_res = {1'b1, w_sum[9:0]};
        end else begin
            if ({1'b0, pos} <= {8'd0, spd}) w_res = {1'b1, 10'd0};
            else                            w_res = {1'b0, pos - {7'd0, spd}};
        end
        return w_res;
    endfunction

    // Control FSM. busy mirrors "state != IDLE" as a register, so a tick that
    // lands in the COMMIT cycle is still seen as busy and counted as dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_speed     <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_done <= 1'b0;
            if (w_tick_ok && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_tick_ok) begin
                        r_state <= c_ST_UPDATE;
                        r_idx   <= '0;
                        r_speed <= speed;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_UPDATE: begin
                    if (r_idx == c_IDX_W'(NUM_OBJ - 1)) begin
                        r_state <= c_ST_COMMIT;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                c_ST_COMMIT: begin
                    r_state     <= c_ST_IDLE;
                    r_idx       <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-object shadow and committed registers. Each object owns its
    // registers, so the update is a simple index match rather than a wide mux.
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
        localparam logic [9:0] c_X0 = 10'(100 + 128 * gi);
        localparam logic [9:0] c_Y0 = 10'(50 + 64 * gi);

        logic [9:0]  r_sx;
        logic [9:0]  r_sy;
        logic        r_dx;
        logic        r_dy;
        logic [9:0]  r_cx;
        logic [9:0]  r_cy;
        logic [10:0] w_nx;
        logic [10:0] w_ny;

        assign w_nx = f_step(r_sx, r_dx, r_speed, c_XLIM);
        assign w_ny = f_step(r_sy, r_dy, r_speed, c_YLIM);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sx <= c_X0;
                r_sy <= c_Y0;
                r_dx <= 1'b1;
                r_dy <= 1'b1;
                r_cx <= c_X0;
                r_cy <= c_Y0;
            end else begin
                if (r_state == c_ST_UPDATE && r_idx == c_IDX_W'(gi)) begin
                    {r_dx, r_sx} <= w_nx;
                    {r_dy, r_sy} <= w_ny;
                end
                if (r_state == c_ST_COMMIT) begin
                    r_cx <= r_sx;
                    r_cy <= r_sy;
                end
            end
        end

        assign obj_x[10*gi +: 10] = r_cx;
        assign obj_y[10*gi +: 10] = r_cy;
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_motion_sched
//  Purpose  : Self-checking bench for sprite_motion_sched. Stimulus tasks push
//             expected frames into a queue; a monitor pops one entry on every
//             done pulse and compares the published positions and count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_motion_sched;

    localparam int NUM_OBJ = 4;
    localparam int W       = 10 * NUM_OBJ;
    localparam int XLIM    = 576;
    localparam int YLIM    = 416;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_tick = 1'b0;
    logic         enable = 1'b1;
    logic         pause = 1'b0;
    logic [2:0]   speed = 3'd0;
    logic [W-1:0] obj_x;
    logic [W-1:0] obj_y;
    logic         busy;
    logic         done;
    logic         overrun;
    logic [7:0]   frame_cnt;

    sprite_motion_sched #(
        .NUM_OBJ  (NUM_OBJ),
        .OBJ_SIZE (64),
        .H_ACT    (640),
        .V_ACT    (480)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .enable     (enable),
        .pause      (pause),
        .speed      (speed),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [7:0]   cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    // reference model state
    int mx[NUM_OBJ];
    int my[NUM_OBJ];
    int mdx[NUM_OBJ];
    int mdy[NUM_OBJ];
    int mcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int step_axis(input int p, input int d, input int s,
                                     input int lim, output int nd);
        nd = d;
        if (s == 0) return p;
        if (d != 0) begin
            if (p + s >= lim) begin nd = 0; return lim; end
            return p + s;
        end
        if (p <= s) begin nd = 1; return 0; end
        return p - s;
    endfunction

    function automatic logic [W-1:0] pack_x();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_OBJ; i++) v[10*i +: 10] = 10'(mx[i]);
        return v;
    endfunction

    function automatic logic [W-1:0] pack_y();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_OBJ; i++) v[10*i +: 10] = 10'(my[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_OBJ; i++) begin
            mx[i]  = 100 + 128 * i;
            my[i]  = 50 + 64 * i;
            mdx[i] = 1;
            mdy[i] = 1;
        end
        mcnt = 0;
    endtask

    task automatic model_frame(input int spd);
        int nd;
        exp_t e;
        for (int i = 0; i < NUM_OBJ; i++) begin
            mx[i]  = step_axis(mx[i], mdx[i], spd, XLIM, nd);
            mdx[i] = nd;
            my[i]  = step_axis(my[i], mdy[i], spd, YLIM, nd);
            mdy[i] = nd;
        end
        mcnt  = (mcnt + 1) % 256;
        e.x   = pack_x();
        e.y   = pack_y();
        e.cnt = 8'(mcnt);
        q.push_back(e);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = q.pop_front();
                chk("sb_obj_x", 64'(obj_x), 64'(mon_e.x));
                chk("sb_obj_y", 64'(obj_y), 64'(mon_e.y));
                chk("sb_frame_cnt", 64'(frame_cnt), 64'(mon_e.cnt));
            end
        end
    end

    task automatic check_reset_state();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_obj_x", 64'(obj_x), 64'({10'd484, 10'd356, 10'd228, 10'd100}));
        chk("rst_obj_y", 64'(obj_y), 64'({10'd242, 10'd178, 10'd114, 10'd50}));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        q.delete();
        check_reset_state();
    endtask

    // Accepted frame with latency / busy / pulse-width checks.
    task automatic run_frame(input int spd, input int spd_after);
        int  n;
        bit  seen;
        @(negedge clk);
        speed      = 3'(spd);
        enable     = 1'b1;
        pause      = 1'b0;
        frame_tick = 1'b1;
        model_frame(spd);
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        speed      = 3'(spd_after);
        n    = 0;
        seen = 1'b0;
        while (n < NUM_OBJ + 8 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) chk("busy_during_update", 64'(busy), 64'd1);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end else begin
            chk("done_latency", 64'(n), 64'(NUM_OBJ + 1));
            chk("busy_at_done", 64'(busy), 64'd0);
            @(posedge clk);
            #1;
            chk("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit saw_busy;

        // reset state
        do_reset();

        // first frame, speed 1
        run_frame(1, 1);
        chk("f1_obj0_x", 64'(obj_x[9:0]), 64'd101);
        chk("f1_obj0_y", 64'(obj_y[9:0]), 64'd51);
        chk("f1_obj3_x", 64'(obj_x[39:30]), 64'd485);
        chk("f1_obj3_y", 64'(obj_y[39:30]), 64'd243);
        chk("f1_frame_cnt", 64'(frame_cnt), 64'd1);

        // speed changed after acceptance must not affect this frame
        run_frame(3, 7);
        chk("spd_sample_obj0_x", 64'(obj_x[9:0]), 64'd104);

        // pause and enable=0 ticks are ignored
        d0 = done_cnt;
        @(negedge clk);
        enable = 1'b1; pause = 1'b1; speed = 3'd3; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; pause = 1'b0; enable = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; enable = 1'b1;
        saw_busy = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (busy) saw_busy = 1'b1;
        end
        chk("gated_busy", 64'(saw_busy), 64'd0);
        chk("gated_done_count", 64'(done_cnt - d0), 64'd0);
        chk("gated_overrun", 64'(overrun), 64'd0);
        chk("gated_obj_x", 64'(obj_x), 64'(pack_x()));
        chk("gated_obj_y", 64'(obj_y), 64'(pack_y()));
        chk("gated_frame_cnt", 64'(frame_cnt), 64'd2);

        // speed 0 still commits but freezes positions
        run_frame(0, 0);
        chk("frozen_obj0_x", 64'(obj_x[9:0]), 64'd104);
        chk("frozen_obj0_y", 64'(obj_y[9:0]), 64'd54);
        chk("frozen_frame_cnt", 64'(frame_cnt), 64'd3);

        // second tick two cycles after the first is dropped
        do_reset();
        d0 = done_cnt;
        @(negedge clk);
        speed = 3'd1; enable = 1'b1; pause = 1'b0; frame_tick = 1'b1;
        model_frame(1);
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_done_count", 64'(done_cnt - d0), 64'd1);
        chk("ovr_frame_cnt", 64'(frame_cnt), 64'd1);
        run_frame(2, 2);
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // reset in the third UPDATE cycle aborts the frame
        d0 = done_cnt;
        @(negedge clk);
        speed = 3'd5; frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        q.delete();
        check_reset_state();
        repeat (10) @(posedge clk);
        #1;
        chk("abort_done_count", 64'(done_cnt - d0), 64'd0);
        chk("abort_obj_x", 64'(obj_x), 64'({10'd484, 10'd356, 10'd228, 10'd100}));
        chk("abort_frame_cnt", 64'(frame_cnt), 64'd0);

        // tick coincident with COMMIT is dropped
        d0 = done_cnt;
        @(negedge clk);
        speed = 3'd2; enable = 1'b1; frame_tick = 1'b1;
        model_frame(2);
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (NUM_OBJ) @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        chk("commit_tick_done", 64'(done), 64'd1);
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("commit_tick_overrun", 64'(overrun), 64'd1);
        chk("commit_tick_busy", 64'(busy), 64'd0);
        chk("commit_tick_done_count", 64'(done_cnt - d0), 64'd1);
        chk("commit_tick_obj0_x", 64'(obj_x[9:0]), 64'd102);

        // X bounce at the right edge
        do_reset();
        for (int i = 0; i < 118; i++) run_frame(4, 4);
        run_frame(2, 2);
        chk("xb_574", 64'(obj_x[9:0]), 64'd574);
        run_frame(4, 4);
        chk("xb_576", 64'(obj_x[9:0]), 64'd576);
        run_frame(4, 4);
        chk("xb_572", 64'(obj_x[9:0]), 64'd572);

        // Y bounce at the top edge
        do_reset();
        for (int i = 0; i < 53; i++) run_frame(7, 7);
        chk("yb_416", 64'(obj_y[9:0]), 64'd416);
        for (int i = 0; i < 59; i++) run_frame(7, 7);
        chk("yb_3", 64'(obj_y[9:0]), 64'd3);
        run_frame(5, 5);
        chk("yb_0", 64'(obj_y[9:0]), 64'd0);
        run_frame(5, 5);
        chk("yb_5", 64'(obj_y[9:0]), 64'd5);

        // frame counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) run_frame((i % 7) + 1, 0);
        chk("cnt_255", 64'(frame_cnt), 64'd255);
        run_frame(1, 0);
        chk("cnt_wrap", 64'(frame_cnt), 64'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_queue_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_motion_sched.md
SPRITE_MOTION_SCHED -- requirements
Module: sprite_motion_sched

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 4: number of bouncing objects scheduled per frame.
REQ-002 SHALL have parameter OBJ_SIZE, default 64: object edge length in pixels.
REQ-003 SHALL have parameter H_ACT, default 640: active horizontal pixels.
REQ-004 SHALL have parameter V_ACT, default 480: active vertical lines.
REQ-005 SHALL have port clk, input, 1: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port frame_tick, input, 1: one-cycle pulse at the start of vertical blanking.
REQ-008 SHALL have port enable, input, 1: gates acceptance of frame_tick.
REQ-009 SHALL have port pause, input, 1: when high, frame_tick is ignored.
REQ-010 SHALL have port speed, input, 3: pixels moved per frame per axis; 0 means frozen.
REQ-011 SHALL have port obj_x, output, 10*NUM_OBJ: committed X of each object; object i is at [10*i+9:10*i].
REQ-012 SHALL have port obj_y, output, 10*NUM_OBJ: committed Y of each object, packed the same way as obj_x.
REQ-013 SHALL have port busy, output, 1: high while the FSM is not in IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse, high in the cycle new positions first appear.
REQ-015 SHALL have port overrun, output, 1: sticky flag; set when a tick is dropped because the block is busy.
REQ-016 SHALL have port frame_cnt, output, 8: count of commits; wraps from 255 to 0.

Function
REQ-017 SHALL implement a 3-state FSM with states IDLE, UPDATE and COMMIT.
REQ-018 SHALL, in IDLE, go to UPDATE with index idx=0 when frame_tick & enable & ~pause is sampled; otherwise stay in IDLE.
REQ-019 SHALL, in UPDATE, process object idx into shadow registers once per cycle.
REQ-020 SHALL, in UPDATE, go to COMMIT after idx=NUM_OBJ-1; otherwise increment idx.
REQ-021 SHALL, in COMMIT, copy all shadow positions to obj_x/obj_y in a single edge, set done=1, increment frame_cnt and return to IDLE.
REQ-022 SHALL never expose a partially updated frame on obj_x/obj_y.
REQ-023 SHALL meet this latency: tick sampled at edge k; shadow updates at edges k+1..k+NUM_OBJ; outputs and done change at edge k+NUM_OBJ+1; done clears at the next edge.
REQ-024 SHALL use per-object limits XLIM=H_ACT-OBJ_SIZE (576) and YLIM=V_ACT-OBJ_SIZE (416), with each axis processed independently.
REQ-025 SHALL, for a positive-direction axis: if pos+speed >= LIM then pos<=LIM and direction becomes negative; else pos<=pos+speed.
REQ-026 SHALL, for a negative-direction axis: if pos <= speed then pos<=0 and direction becomes positive; else pos<=pos-speed.
REQ-027 SHALL, when speed=0, hold position and direction for all objects while still running UPDATE, COMMIT and done.
REQ-028 SHALL perform comparisons in at least 11 bits so that the sum never wraps.
REQ-029 SHALL keep positions within 0..LIM at all times.
REQ-030 SHALL sample speed once, at tick acceptance, and use it for the whole frame.
REQ-031 SHALL, for frame_tick sampled while busy=1, ignore it and set overrun=1.
REQ-032 SHALL clear overrun only by rst.
REQ-033 SHALL treat a frame_tick coincident with the COMMIT cycle as dropped and set overrun.
REQ-034 SHALL, for frame_tick with enable=0 or pause=1, take no action, with no overrun and no done.
REQ-035 SHALL keep busy registered: 1 from edge k+1 through the COMMIT cycle, and 0 from edge k+NUM_OBJ+1.

Reset
REQ-036 SHALL, on rst=1 at an edge, force state=IDLE, idx=0, busy=0, done=0, overrun=0 and frame_cnt=0.
REQ-037 SHALL, on reset, set object i (both shadow and committed) to x=100+128*i, y=50+64*i, with both directions positive.
REQ-038 SHALL, on rst asserted mid-UPDATE, abort without a commit; outputs show reset values at the next edge.
REQ-039 SHALL give rst priority over frame_tick in the same cycle.

Verification
REQ-040 SHALL cover: reset, then tick with speed=1 -> after 5 cycles done pulses once; obj0=(101,51), obj3=(485,243); frame_cnt=1.
REQ-041 SHALL cover: object 0 at x=574, dir+, speed=4 -> x=576 and dir- after the commit; the next frame gives x=572.
REQ-042 SHALL cover: y=3, dir-, speed=5 -> y=0 and dir+; the next frame gives y=5.
REQ-043 SHALL cover: second tick 2 cycles after the first -> ignored, overrun=1, only one done, frame_cnt=1.
REQ-044 SHALL cover: pause=1 or enable=0 with a tick -> busy stays 0, no done, positions unchanged; speed=0 tick -> done pulses, positions unchanged.
REQ-045 SHALL cover: rst in the 3rd UPDATE cycle -> no done, outputs equal reset values, frame_cnt=0; 256 commits -> frame_cnt wraps to 0.
